// File: rtl/ddrc_pkg.sv
// Shared constants for the DDR controller write-side control block:
// register indices, phase-shift FSM encoding and CTRL bit positions.
package ddrc_pkg;

  localparam logic [1:0] REG_RUN    = 2'd0;
  localparam logic [1:0] REG_PS_SET = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] PS_IDLE    = 2'd0;
  localparam logic [1:0] PS_REQ     = 2'd1;
  localparam logic [1:0] PS_WAIT_LO = 2'd2;
  localparam logic [1:0] PS_WAIT_HI = 2'd3;

  localparam int CTRL_BITS     = 4;
  localparam int CTRL_MMCM_RST = 0;
  localparam int CTRL_DLY_RST  = 1;
  localparam int CTRL_DCI_RST  = 2;
  localparam int CTRL_DDR_RST  = 3;
  localparam int CTRL_CLR_ERR  = 7;

endpackage

// File: rtl/ddrc_ps_fsm.sv
// MMCM phase-shift handshake: request pulse, wait for ready to drop and
// return, with a per-phase timeout that raises a sticky error flag.
module ddrc_ps_fsm
  import ddrc_pkg::*;
#(
  parameter int PS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps_set_wr,
  input  logic [7:0] ps_target,
  input  logic       clr_err,
  input  logic       ps_rdy,
  input  logic [7:0] ps_out,
  output logic [7:0] ps_in,
  output logic       ps_we,
  output logic       ps_err,
  output logic       idle
);

  localparam logic [7:0] TIMEOUT = 8'(PS_TIMEOUT);

  logic [1:0] state, state_next;
  logic [7:0] cnt, cnt_next, cnt_inc;
  logic       timeout;

  assign cnt_inc = cnt + 8'd1;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path through the case statement can leave one unassigned (latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    timeout    = 1'b0;
    case (state)
      PS_IDLE: begin
        if (ps_set_wr && (ps_target != ps_out)) state_next = PS_REQ;
      end
      PS_REQ: begin
        state_next = PS_WAIT_LO;
        cnt_next   = '0;
      end
      PS_WAIT_LO: begin
        if (!ps_rdy) begin
          state_next = PS_WAIT_HI;
          cnt_next   = '0;
        end else if (cnt_inc == TIMEOUT) begin
          timeout    = 1'b1;
          state_next = PS_IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PS_WAIT_HI: begin
        if (ps_rdy) begin
          state_next = PS_IDLE;
        end else if (cnt_inc == TIMEOUT) begin
          timeout    = 1'b1;
          state_next = PS_IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = PS_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PS_IDLE;
      cnt    <= '0;
      ps_in  <= '0;
      ps_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if ((state == PS_IDLE) && ps_set_wr) ps_in <= ps_target;
      // A timeout in the same cycle as a clear request leaves the flag set.
      if (clr_err) ps_err <= 1'b0;
      if (timeout) ps_err <= 1'b1;
    end
  end

  assign ps_we = (state == PS_REQ);
  assign idle  = (state == PS_IDLE);

endmodule

// File: rtl/ddrc_control.sv
// Write-side control for the DDR controller: decodes AXI register writes into
// sequencer-run requests, MMCM phase shifts and level control bits.
module ddrc_control
  import ddrc_pkg::*;
#(
  parameter int                          AXI_WR_ADDR_BITS = 12,
  parameter logic [AXI_WR_ADDR_BITS-1:0] SELECT_ADDR      = 'h800,
  parameter logic [AXI_WR_ADDR_BITS-1:0] SELECT_ADDR_MASK = 'h800,
  parameter int                          PS_TIMEOUT       = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_WR_ADDR_BITS-1:0] pre_waddr,
  input  logic                        start_wburst,
  input  logic [AXI_WR_ADDR_BITS-1:0] waddr,
  input  logic                        wr_en,
  input  logic [31:0]                 wdata,
  output logic                        busy,
  input  logic                        run_busy,
  output logic [10:0]                 run_addr,
  output logic                        run_seq,
  input  logic                        ps_rdy,
  input  logic [7:0]                  ps_out,
  output logic [7:0]                  ps_in,
  output logic                        ps_we,
  output logic                        ps_err,
  output logic [CTRL_BITS-1:0]        ctrl
);

  logic       sel_wr, sel_pre;
  logic [1:0] wr_idx, pre_idx;
  logic       wr_run, wr_ps, wr_ctrl;
  logic       run_pending;
  logic       run_fire;
  logic       ps_idle;
  logic       unused_wdata;

  assign sel_wr  = (waddr & SELECT_ADDR_MASK) == SELECT_ADDR;
  assign sel_pre = (pre_waddr & SELECT_ADDR_MASK) == SELECT_ADDR;
  assign wr_idx  = waddr[1:0];
  assign pre_idx = pre_waddr[1:0];

  assign wr_run  = wr_en && sel_wr && (wr_idx == REG_RUN);
  assign wr_ps   = wr_en && sel_wr && (wr_idx == REG_PS_SET);
  assign wr_ctrl = wr_en && sel_wr && (wr_idx == REG_CTRL);

  assign unused_wdata = ^wdata[31:11];

  assign run_fire = run_pending && !run_busy;

  // A write landing on the firing edge re-arms the request with the new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_addr    <= '0;
      run_pending <= 1'b0;
      run_seq     <= 1'b0;
    end else begin
      run_seq <= run_fire;
      if (wr_run) begin
        run_addr    <= wdata[10:0];
        run_pending <= 1'b1;
      end else if (run_fire) begin
        run_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl <= wdata[CTRL_BITS-1:0];
    end
  end

  ddrc_ps_fsm #(
    .PS_TIMEOUT(PS_TIMEOUT)
  ) u_ps_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps_set_wr(wr_ps),
    .ps_target(wdata[7:0]),
    .clr_err  (wr_ctrl && wdata[CTRL_CLR_ERR]),
    .ps_rdy   (ps_rdy),
    .ps_out   (ps_out),
    .ps_in    (ps_in),
    .ps_we    (ps_we),
    .ps_err   (ps_err),
    .idle     (ps_idle)
  );

  // Stall a burst only when the engine it targets cannot take a command yet.
  assign busy = start_wburst && sel_pre &&
                (((pre_idx == REG_PS_SET) && !ps_idle) ||
                 ((pre_idx == REG_RUN) && run_pending));

endmodule

// File: tb/tb_ddrc_control.sv
// Scoreboard bench for ddrc_control: expected run/phase-shift commands are
// queued at issue time and matched by a monitor when the DUT pulses.
module tb_ddrc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pre_waddr;
  logic        start_wburst;
  logic [11:0] waddr;
  logic        wr_en;
  logic [31:0] wdata;
  logic        busy;
  logic        run_busy;
  logic [10:0] run_addr;
  logic        run_seq;
  logic        ps_rdy;
  logic [7:0]  ps_out;
  logic [7:0]  ps_in;
  logic        ps_we;
  logic        ps_err;
  logic [3:0]  ctrl;

  ddrc_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_waddr   (pre_waddr),
    .start_wburst(start_wburst),
    .waddr       (waddr),
    .wr_en       (wr_en),
    .wdata       (wdata),
    .busy        (busy),
    .run_busy    (run_busy),
    .run_addr    (run_addr),
    .run_seq     (run_seq),
    .ps_rdy      (ps_rdy),
    .ps_out      (ps_out),
    .ps_in       (ps_in),
    .ps_we       (ps_we),
    .ps_err      (ps_err),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] run_q[$];
  logic [7:0]  ps_q[$];
  bit          model_ps_active = 1'b0;
  bit          mmcm_stuck      = 1'b0;
  int          mmcm_lo         = 20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Monitor: every command pulse must match the oldest outstanding expectation.
  initial begin
    logic [10:0] exp_run;
    logic [7:0]  exp_ps;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (run_seq === 1'b1) begin
          if (run_q.size() == 0) check("run_seq_unexpected", 32'(run_seq), 32'd0);
          else begin
            exp_run = run_q.pop_front();
            check("run_addr_at_pulse", 32'(run_addr), 32'(exp_run));
          end
        end
        if (ps_we === 1'b1) begin
          if (ps_q.size() == 0) check("ps_we_unexpected", 32'(ps_we), 32'd0);
          else begin
            exp_ps = ps_q.pop_front();
            check("ps_in_at_pulse", 32'(ps_in), 32'(exp_ps));
          end
        end
      end
    end
  end

  // MMCM model: after a request, ready drops for mmcm_lo cycles and the phase moves.
  initial begin
    logic [7:0] target;
    ps_rdy = 1'b1;
    ps_out = 8'd10;
    forever begin
      @(negedge clk);
      if (ps_we === 1'b1 && !mmcm_stuck) begin
        target = ps_in;
        ps_rdy = 1'b0;
        repeat (mmcm_lo) @(negedge clk);
        ps_out = target;
        ps_rdy = 1'b1;
        model_ps_active = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    waddr = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_write(input logic [10:0] a);
    if (run_busy && run_q.size() > 0) run_q[run_q.size()-1] = a;
    else run_q.push_back(a);
    axi_write(12'h800, {21'd0, a});
  endtask

  task automatic ps_write(input logic [7:0] v);
    if (!model_ps_active && v != ps_out) begin
      ps_q.push_back(v);
      model_ps_active = 1'b1;
    end
    axi_write(12'h801, {24'd0, v});
  endtask

  task automatic check_busy(input string name, input logic [11:0] a, input logic exp);
    pre_waddr    = a;
    start_wburst = 1'b1;
    #1;
    check(name, 32'(busy), 32'(exp));
    start_wburst = 1'b0;
  endtask

  task automatic wait_run_drained(input int limit);
    for (int i = 0; i < limit && run_q.size() != 0; i++) @(negedge clk);
    check("run_pulse_within_bound", 32'(run_q.size()), 32'd0);
  endtask

  task automatic wait_ps_done(input int limit);
    for (int i = 0; i < limit && model_ps_active; i++) @(negedge clk);
    check("ps_handshake_within_bound", 32'(model_ps_active), 32'd0);
  endtask

  initial begin
    logic [7:0]  v;
    logic [10:0] a;
    int          n;
    int          waited;

    rst_n = 1'b0; pre_waddr = '0; start_wburst = 1'b0; waddr = '0;
    wr_en = 1'b0; wdata = '0; run_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_run_addr", 32'(run_addr), 32'd0);
    check("reset_run_seq", 32'(run_seq), 32'd0);
    check("reset_ps_in", 32'(ps_in), 32'd0);
    check("reset_ps_we", 32'(ps_we), 32'd0);
    check("reset_ps_err", 32'(ps_err), 32'd0);
    check("reset_ctrl", 32'(ctrl), 32'd0);
    rst_n = 1'b1;

    // CTRL, reserved index and unselected addresses.
    axi_write(12'h802, 32'h5);
    check("ctrl_write", 32'(ctrl), 32'h5);
    axi_write(12'h803, 32'hFF);
    check("reserved_ctrl_kept", 32'(ctrl), 32'h5);
    check("reserved_ps_in_kept", 32'(ps_in), 32'd0);
    axi_write(12'h402, 32'hA);
    check("unselected_ctrl_kept", 32'(ctrl), 32'h5);
    axi_write(12'h400, 32'h55);
    check("unselected_run_addr_kept", 32'(run_addr), 32'd0);

    // RUN held off by run_busy.
    run_busy = 1'b1;
    run_write(11'h123);
    repeat (3) @(negedge clk);
    check("run_held_no_pulse", 32'(run_seq), 32'd0);
    check("run_held_addr", 32'(run_addr), 32'h123);
    check_busy("busy_run_pending", 12'h800, 1'b1);
    check_busy("busy_unselected", 12'h400, 1'b0);
    check_busy("busy_ps_idle", 12'h801, 1'b0);
    @(negedge clk);
    run_busy = 1'b0;
    @(negedge clk);
    check("run_seq_after_release", 32'(run_seq), 32'd1);
    @(negedge clk);
    check("run_seq_one_cycle", 32'(run_seq), 32'd0);
    check_busy("busy_run_cleared", 12'h800, 1'b0);

    // RUN overwrite while held off.
    run_busy = 1'b1;
    run_write(11'h010);
    run_write(11'h020);
    repeat (2) @(negedge clk);
    run_busy = 1'b0;
    wait_run_drained(10);
    repeat (3) @(negedge clk);

    // Phase shift, normal handshake.
    mmcm_lo = 20;
    ps_write(8'd30);
    check("ps_we_latency", 32'(ps_we), 32'd1);
    check("ps_in_loaded", 32'(ps_in), 32'd30);
    @(negedge clk);
    check("ps_we_one_cycle", 32'(ps_we), 32'd0);
    check_busy("busy_ps_active", 12'h801, 1'b1);
    check_busy("busy_run_during_ps", 12'h800, 1'b0);
    ps_write(8'd99);
    check("ps_write_ignored_when_busy", 32'(ps_in), 32'd30);
    wait_ps_done(100);
    repeat (2) @(negedge clk);
    check("ps_normal_no_err", 32'(ps_err), 32'd0);
    check_busy("busy_ps_back_idle", 12'h801, 1'b0);

    // No-op: target equals current phase.
    ps_write(ps_out);
    repeat (3) @(negedge clk);
    check_busy("busy_ps_noop", 12'h801, 1'b0);

    // Timeout with ready stuck high.
    mmcm_stuck = 1'b1;
    if (ps_out == 8'd5) ps_write(8'd6); else ps_write(8'd5);
    repeat (200) @(negedge clk);
    check("ps_err_not_early", 32'(ps_err), 32'd0);
    check_busy("busy_ps_waiting", 12'h801, 1'b1);
    waited = 0;
    while (ps_err !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ps_timeout_flag", 32'(ps_err), 32'd1);
    model_ps_active = 1'b0;
    mmcm_stuck = 1'b0;
    @(negedge clk);
    check_busy("busy_after_timeout", 12'h801, 1'b0);
    axi_write(12'h802, 32'h80);
    check("ps_err_cleared", 32'(ps_err), 32'd0);
    check("ctrl_after_clear", 32'(ctrl), 32'd0);

    // Randomized phase shifts.
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      mmcm_lo = $urandom_range(1, 40);
      ps_write(v);
      wait_ps_done(100);
      repeat (2) @(negedge clk);
      check("rand_ps_no_err", 32'(ps_err), 32'd0);
      check("rand_ps_in", 32'(ps_in), 32'(v));
    end

    // Randomized RUN traffic, held off or free-running.
    for (int i = 0; i < 6; i++) begin
      run_busy = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        a = 11'($urandom_range(0, 2047));
        run_write(a);
        if (!run_busy) repeat (2) @(negedge clk);
      end
      run_busy = 1'b0;
      wait_run_drained(10);
      repeat (2) @(negedge clk);
    end

    // Reset mid-handshake with a pending run and non-zero control bits.
    axi_write(12'h802, 32'hA);
    run_busy = 1'b1;
    run_write(11'h3AB);
    mmcm_lo = 100;
    ps_write(ps_out ^ 8'h80);
    repeat (10) @(negedge clk);
    check_busy("busy_before_reset", 12'h801, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_run_addr", 32'(run_addr), 32'd0);
    check("rst_mid_run_seq", 32'(run_seq), 32'd0);
    check("rst_mid_ps_in", 32'(ps_in), 32'd0);
    check("rst_mid_ps_we", 32'(ps_we), 32'd0);
    check("rst_mid_ps_err", 32'(ps_err), 32'd0);
    check("rst_mid_ctrl", 32'(ctrl), 32'd0);
    run_q.delete();
    ps_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_busy("busy_after_reset_ps", 12'h801, 1'b0);
    check_busy("busy_after_reset_run", 12'h800, 1'b0);
    wait_ps_done(150);

    repeat (5) @(negedge clk);
    check("run_queue_empty", 32'(run_q.size()), 32'd0);
    check("ps_queue_empty", 32'(ps_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddrc_control.md
# ddrc_control

Write-side control block for the DDR controller: the AXI register-write counterpart to the status readback path. It decodes AXI writes into three actions:
- a sequencer-run request, handed off to the sequencer once it is idle;
- an MMCM phase-shift request, managed by a handshake state machine;
- a level-type control register (resets, enables).

It sits between the AXI write channel adapter and the sequencer/MMCM wrapper. It reports `busy` so that the adapter stalls bursts aimed at an engine that cannot yet accept a command.

## Interface
Parameters:
- `AXI_WR_ADDR_BITS`, 12: write address width.
- `SELECT_ADDR`, 'h800: address value selecting this block.
- `SELECT_ADDR_MASK`, 'h800: mask applied before comparing with `SELECT_ADDR`.
- `PS_TIMEOUT`, 255: maximum cycles to wait in each phase-shift handshake phase; range 1..255.

Ports:
- `clk` in 1: single clock. All logic is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pre_waddr` in `AXI_WR_ADDR_BITS`: burst address, valid with `start_wburst`.
- `start_wburst` in 1: write burst start.
- `waddr` in `AXI_WR_ADDR_BITS`: write address, valid with `wr_en`.
- `wr_en` in 1: write strobe.
- `wdata` in 32: write data.
- `busy` out 1: combinational stall request to the adapter.
- `run_busy` in 1: sequencer busy.
- `run_addr` out 11: sequence start address.
- `run_seq` out 1: one-cycle sequencer start pulse.
- `ps_rdy` in 1: MMCM phase-shift ready.
- `ps_out` in 8: current MMCM phase.
- `ps_in` out 8: target phase presented to the MMCM wrapper.
- `ps_we` out 1: one-cycle phase-shift request pulse.
- `ps_err` out 1: sticky timeout flag.
- `ctrl` out 4: level control bits, consumed as {`ddr_rst`, `dci_rst`, `dly_rst`, `mmcm_rst`}, MSB to LSB.

## Operation
- **Select and decode.** An address is selected when (`waddr` & `SELECT_ADDR_MASK`) == `SELECT_ADDR`. The register index is `waddr[1:0]`:
  - 0 = RUN
  - 1 = PS_SET
  - 2 = CTRL
  - 3 = reserved; writes are ignored.
- **RUN register.**
  - A write loads `run_addr` <= `wdata[10:0]` and sets `run_pending`.
  - When `run_pending` && !`run_busy`: assert `run_seq` for one cycle and clear `run_pending`.
  - A new write while `run_pending` is set overwrites `run_addr`. Only one pulse is issued.
  - A write arriving in the same cycle that `run_seq` fires sets `run_pending` again and loads the new address.
- **CTRL register.**
  - A write loads `ctrl` <= `wdata[3:0]`.
  - `wdata[7]` = 1 clears `ps_err`.
- **Phase-shift FSM.** States are IDLE, REQ, WAIT_LO, WAIT_HI.
  - IDLE: on a PS_SET write, `ps_in` <= `wdata[7:0]`. If `wdata[7:0]` == `ps_out`, stay in IDLE (no-op). Otherwise go to REQ.
  - REQ: `ps_we` = 1 for exactly one cycle, then go to WAIT_LO with the counter cleared.
  - WAIT_LO: wait for `ps_rdy` = 0, then go to WAIT_HI with the counter cleared.
  - WAIT_HI: wait for `ps_rdy` = 1, then go to IDLE.
  - Timeout: in WAIT_LO or WAIT_HI, if the counter reaches `PS_TIMEOUT`, set `ps_err` and go to IDLE.
  - PS_SET writes while the FSM is not in IDLE are ignored.
- **busy.** `busy` = `start_wburst` && selected(`pre_waddr`) && one of:
  - (index 1 && state != IDLE), or
  - (index 0 && `run_pending`).

## Timing
- **Reset values:** `run_addr` = 0, `run_seq` = 0, `ps_in` = 0, `ps_we` = 0, `ps_err` = 0, `ctrl` = 0, `run_pending` = 0, FSM in IDLE. `busy` has no reset value because it is combinational.
- **Reset mid-operation:** an asynchronous reset aborts any handshake. Pulses drop immediately and no pending command survives.
- **Register latency:** `run_addr`, `ctrl` and `ps_in` update on the edge that samples `wr_en`.
- **`run_seq` latency:** earliest one cycle after the write, then held off for as long as `run_busy` = 1.
- **`ps_we` latency:** one cycle after the PS_SET write (the REQ state).
- **Counter:** 8 bits, incrementing once per cycle in WAIT_LO and WAIT_HI. `ps_err` is set on the cycle the count equals `PS_TIMEOUT`.
- **Simultaneous events:**
  - A CTRL write with bit 7 set in the same cycle as a timeout: the timeout wins, so `ps_err` = 1.
  - `ps_rdy` is sampled at 0 in REQ: this does not count. Only WAIT_LO samples it.

## Structure
- **Shared package `ddrc_pkg`:**
  - register index constants: RUN = 0, PS_SET = 1, CTRL = 2;
  - phase-shift FSM state encoding;
  - CTRL bit positions.
- **One sub-module:** `ddrc_ps_fsm`, the phase-shift handshake FSM with its timeout counter. It owns `ps_in`, `ps_we`, `ps_err` and the idle indication.
- **Top level:** decode, the RUN and CTRL registers, and `busy`.

## Test plan
- **Reset state:** assert `rst_n` = 0 mid-handshake (state WAIT_HI) -> all outputs 0 at once; after release, FSM is IDLE and `busy` = 0.
- **RUN held off:** write RUN `wdata` = 'h123 while `run_busy` = 1 -> no pulse. Drop `run_busy` -> `run_addr` = 'h123 and one `run_seq` pulse on the next cycle.
- **RUN overwrite:** two RUN writes ('h010, then 'h020) while `run_busy` = 1 -> a single `run_seq` with `run_addr` = 'h020.
- **Phase shift, normal:** `ps_out` = 10, write PS_SET 30 -> `ps_we` one cycle with `ps_in` = 30. Model `ps_rdy` low for 20 cycles -> FSM returns to IDLE and `ps_err` = 0. During the shift, a burst at PS_SET gives `busy` = 1.
- **Phase shift, no-op and timeout:**
  - Write PS_SET equal to `ps_out` -> no `ps_we`.
  - Write PS_SET 5 with `ps_rdy` stuck at 1 -> `ps_err` = 1 after 255 cycles in WAIT_LO.
  - Write CTRL 'h80 -> `ps_err` = 0.
- **CTRL and reserved:** write CTRL 'h5 -> `ctrl` = 4'b0101. Write index 3 -> no change. An unselected address ('h400) -> no change.
